// File: rtl/brimstone_pkg.sv
// Shared core constants: datapath width, instruction size and reset fetch address.
package brimstone_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC = '0;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !clear && do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: credit-limited in-order memory reads, response buffering, redirect flush.
module instruction_fetch
    import brimstone_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_P = XLEN,
    parameter int unsigned ADDR_WIDTH_P = XLEN,
    parameter int unsigned FIFO_DEPTH_P = 4,
    parameter logic [ADDR_WIDTH_P-1:0] RESET_PC_P = ADDR_WIDTH_P'(RESET_PC)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_redirect,
    input  logic [ADDR_WIDTH_P-1:0] i_redirect_pc,
    output logic                    o_imem_req_valid,
    input  logic                    i_imem_req_ready,
    output logic [ADDR_WIDTH_P-1:0] o_imem_req_addr,
    input  logic                    i_imem_rsp_valid,
    input  logic [DATA_WIDTH_P-1:0] i_imem_rsp_data,
    output logic                    o_inst_valid,
    input  logic                    i_inst_ready,
    output logic [DATA_WIDTH_P-1:0] o_inst,
    output logic [ADDR_WIDTH_P-1:0] o_inst_pc,
    output logic                    o_rsp_err
);

    localparam int unsigned CW  = $clog2(FIFO_DEPTH_P) + 1;
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned FW  = DATA_WIDTH_P + ADDR_WIDTH_P;
    localparam logic [CW:0] DEPTH_C = CW1'(FIFO_DEPTH_P);
    localparam logic [ADDR_WIDTH_P-1:0] STEP = ADDR_WIDTH_P'(INST_BYTES);

    logic [ADDR_WIDTH_P-1:0] req_pc_q, req_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]           outstanding_q, outstanding_d, drop_q, drop_d, fifo_count;
    logic                    rsp_err_q, rsp_err_d;
    logic                    fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic                    issue, rsp_hit;
    logic [FW-1:0]           fifo_din, fifo_dout;
    logic [CW:0]             credits_used;

    // Every outstanding request owns a FIFO slot, so responses can never be refused.
    assign credits_used     = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign o_imem_req_valid = reset && !i_redirect && !fifo_full && (credits_used < DEPTH_C);
    assign o_imem_req_addr  = req_pc_q;
    assign issue            = o_imem_req_valid && i_imem_req_ready;

    assign rsp_hit   = reset && i_imem_rsp_valid && (outstanding_q != '0);
    assign fifo_push = rsp_hit && !i_redirect && (drop_q == '0);
    assign fifo_din  = {i_imem_rsp_data, rsp_pc_q};

    assign o_inst_valid       = reset && !fifo_empty && !i_redirect;
    assign fifo_pop           = o_inst_valid && i_inst_ready;
    assign {o_inst, o_inst_pc} = fifo_dout;
    assign o_rsp_err          = rsp_err_q;

    always_comb begin
        req_pc_d      = req_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        rsp_err_d     = rsp_err_q || (i_imem_rsp_valid && (outstanding_q == '0));
        if (i_redirect) begin
            req_pc_d      = i_redirect_pc;
            rsp_pc_d      = i_redirect_pc;
            outstanding_d = outstanding_q - CW'(rsp_hit);
            // Everything still in flight belongs to the abandoned path.
            drop_d        = outstanding_q - CW'(rsp_hit);
        end else begin
            if (issue) req_pc_d = req_pc_q + STEP;
            outstanding_d = outstanding_q + CW'(issue) - CW'(rsp_hit);
            if (rsp_hit) begin
                if (drop_q != '0) drop_d = drop_q - CW'(1);
                else              rsp_pc_d = rsp_pc_q + STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            req_pc_q      <= RESET_PC_P;
            rsp_pc_q      <= RESET_PC_P;
            outstanding_q <= '0;
            drop_q        <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH_P)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (i_redirect),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-configurable memory model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req_valid;
    logic        mem_rdy;
    logic [31:0] o_imem_req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        o_inst_valid;
    logic        dec_rdy;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_rsp_err;

    logic        mem_en;
    int          mem_lat;
    logic        mdl_valid;
    logic [31:0] mdl_data;
    logic        inj_valid;
    logic [31:0] inj_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rsp_valid = mem_en ? mdl_valid : inj_valid;
    assign rsp_data  = mem_en ? mdl_data  : inj_data;

    instruction_fetch dut (
        .clk              (clk),
        .reset            (reset),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (mem_rdy),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .o_inst_valid     (o_inst_valid),
        .i_inst_ready     (dec_rdy),
        .o_inst           (o_inst),
        .o_inst_pc        (o_inst_pc),
        .o_rsp_err        (o_rsp_err)
    );

    // Memory returns ~addr, in order, mem_lat cycles after acceptance.
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    int          cyc = 0;

    initial begin
        mdl_valid = 1'b0;
        mdl_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                pend_addr.delete();
                pend_due.delete();
            end else if (o_imem_req_valid && mem_rdy) begin
                pend_addr.push_back(o_imem_req_addr);
                pend_due.push_back(cyc + mem_lat - 1);
            end
            #1;
            mdl_valid = 1'b0;
            if (mem_en && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                mdl_valid = 1'b1;
                mdl_data  = ~pend_addr[0];
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        tick();
        reset      = 1'b0;
        i_redirect = 1'b0;
        inj_valid  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        tick();
        reset = 1'b0;
        tick();
        n_checks += 4;
        if (o_imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_req_valid got %0b want 0", o_imem_req_valid);
        end
        if (o_inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_inst_valid got %0b want 0", o_inst_valid);
        end
        if (o_rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp_err got %0b want 0", o_rsp_err);
        end
        if (o_imem_req_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_req_addr got %h want 0", o_imem_req_addr);
        end
        reset = 1'b1;
        #1;
        n_checks += 2;
        if (o_imem_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL release_req_valid got %0b want 1", o_imem_req_valid);
        end
        if (o_inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL release_inst_valid got %0b want 0", o_inst_valid);
        end
    endtask

    task automatic test_stream;
        logic [31:0] exp_req, exp_pc;
        int nreq, ninst;
        mem_lat = 1; mem_rdy = 1'b1; dec_rdy = 1'b1;
        do_reset();
        exp_req = 32'h0; exp_pc = 32'h0; nreq = 0; ninst = 0;
        for (int i = 0; i < 11; i++) begin
            if (o_imem_req_valid && mem_rdy) begin
                n_checks++;
                if (o_imem_req_addr !== exp_req) begin
                    n_fail++; $display("FAIL stream_req_addr got %h want %h", o_imem_req_addr, exp_req);
                end
                exp_req += 32'd4; nreq++;
            end
            if (o_inst_valid) begin
                n_checks += 2;
                if (o_inst_pc !== exp_pc) begin
                    n_fail++; $display("FAIL stream_pc got %h want %h", o_inst_pc, exp_pc);
                end
                if (o_inst !== ~exp_pc) begin
                    n_fail++; $display("FAIL stream_data got %h want %h", o_inst, ~exp_pc);
                end
                exp_pc += 32'd4; ninst++;
            end
            tick();
        end
        n_checks += 2;
        if (nreq != 11) begin
            n_fail++; $display("FAIL stream_req_count got %0d want 11", nreq);
        end
        if (ninst != 9) begin
            n_fail++; $display("FAIL stream_throughput got %0d want 9", ninst);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_req, exp_pc;
        int nreq, ndrain;
        logic seen;
        mem_lat = 2; mem_rdy = 1'b1; dec_rdy = 1'b0;
        do_reset();
        exp_req = 32'h0; nreq = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_imem_req_valid && mem_rdy) begin
                n_checks++;
                if (o_imem_req_addr !== exp_req) begin
                    n_fail++; $display("FAIL bp_req_addr got %h want %h", o_imem_req_addr, exp_req);
                end
                exp_req += 32'd4; nreq++;
            end
            tick();
        end
        n_checks += 4;
        if (nreq != 4) begin
            n_fail++; $display("FAIL bp_req_count got %0d want 4", nreq);
        end
        if (o_imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_credit_stall got %0b want 0", o_imem_req_valid);
        end
        if (o_inst_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_held_valid got %0b want 1", o_inst_valid);
        end
        if (o_inst_pc !== 32'h0) begin
            n_fail++; $display("FAIL bp_head_pc got %h want 0", o_inst_pc);
        end
        dec_rdy = 1'b1;
        #1;
        exp_pc = 32'h0; ndrain = 0; seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (o_inst_valid && ndrain < 4) begin
                n_checks += 2;
                if (o_inst_pc !== exp_pc) begin
                    n_fail++; $display("FAIL bp_drain_pc got %h want %h", o_inst_pc, exp_pc);
                end
                if (o_inst !== ~exp_pc) begin
                    n_fail++; $display("FAIL bp_drain_data got %h want %h", o_inst, ~exp_pc);
                end
                exp_pc += 32'd4; ndrain++;
            end
            if (o_imem_req_valid && mem_rdy && !seen) begin
                n_checks++;
                if (o_imem_req_addr !== 32'h10) begin
                    n_fail++; $display("FAIL bp_resume_addr got %h want 00000010", o_imem_req_addr);
                end
                seen = 1'b1;
            end
            tick();
        end
        n_checks += 2;
        if (ndrain != 4) begin
            n_fail++; $display("FAIL bp_drain_count got %0d want 4", ndrain);
        end
        if (seen !== 1'b1) begin
            n_fail++; $display("FAIL bp_resume_seen got %0b want 1", seen);
        end
    endtask

    task automatic test_redirect;
        logic [31:0] exp_pc;
        int nseen;
        mem_lat = 5; mem_rdy = 1'b1; dec_rdy = 1'b1;
        do_reset();
        i_redirect = 1'b1; i_redirect_pc = 32'h20;
        tick();
        i_redirect = 1'b0;
        tick(); tick(); tick();
        // Requests 0x20, 0x24, 0x28 are now in flight.
        i_redirect = 1'b1; i_redirect_pc = 32'h100;
        #1;
        n_checks += 2;
        if (o_imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_req_blocked got %0b want 0", o_imem_req_valid);
        end
        if (o_inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_none_returned got %0b want 0", o_inst_valid);
        end
        tick();
        i_redirect = 1'b0;
        #1;
        exp_pc = 32'h100; nseen = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_inst_valid && nseen < 2) begin
                n_checks += 2;
                if (o_inst_pc !== exp_pc) begin
                    n_fail++; $display("FAIL redir_pc got %h want %h", o_inst_pc, exp_pc);
                end
                if (o_inst !== ~exp_pc) begin
                    n_fail++; $display("FAIL redir_data got %h want %h", o_inst, ~exp_pc);
                end
                exp_pc += 32'd4; nseen++;
            end
            tick();
        end
        n_checks++;
        if (nseen != 2) begin
            n_fail++; $display("FAIL redir_inst_count got %0d want 2", nseen);
        end
    endtask

    task automatic test_redirect_with_rsp;
        logic [31:0] exp_pc;
        int nseen;
        mem_lat = 2; mem_rdy = 1'b1; dec_rdy = 1'b0;
        do_reset();
        tick(); tick(); tick(); tick();
        // Two words buffered, response for 0x8 on the bus, 0xC still outstanding.
        n_checks++;
        if (o_inst_valid !== 1'b1) begin
            n_fail++; $display("FAIL rr_setup_valid got %0b want 1", o_inst_valid);
        end
        i_redirect = 1'b1; i_redirect_pc = 32'h200; dec_rdy = 1'b1;
        #1;
        n_checks += 2;
        if (o_inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL rr_valid_masked got %0b want 0", o_inst_valid);
        end
        if (o_imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rr_req_masked got %0b want 0", o_imem_req_valid);
        end
        tick();
        i_redirect = 1'b0;
        #1;
        n_checks++;
        if (o_inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL rr_fifo_cleared got %0b want 0", o_inst_valid);
        end
        exp_pc = 32'h200; nseen = 0;
        for (int i = 0; i < 15; i++) begin
            if (o_inst_valid && nseen < 2) begin
                n_checks += 2;
                if (o_inst_pc !== exp_pc) begin
                    n_fail++; $display("FAIL rr_pc got %h want %h", o_inst_pc, exp_pc);
                end
                if (o_inst !== ~exp_pc) begin
                    n_fail++; $display("FAIL rr_data got %h want %h", o_inst, ~exp_pc);
                end
                exp_pc += 32'd4; nseen++;
            end
            tick();
        end
        n_checks++;
        if (nseen != 2) begin
            n_fail++; $display("FAIL rr_inst_count got %0d want 2", nseen);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_req, exp_pc;
        int nreq, ninst;
        mem_lat = 1; mem_rdy = 1'b1; dec_rdy = 1'b1;
        do_reset();
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
        tick();
        i_redirect = 1'b0;
        #1;
        exp_req = 32'hFFFF_FFFC; exp_pc = 32'hFFFF_FFFC; nreq = 0; ninst = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_imem_req_valid && mem_rdy && nreq < 3) begin
                n_checks++;
                if (o_imem_req_addr !== exp_req) begin
                    n_fail++; $display("FAIL wrap_req_addr got %h want %h", o_imem_req_addr, exp_req);
                end
                exp_req += 32'd4; nreq++;
            end
            if (o_inst_valid && ninst < 3) begin
                n_checks += 2;
                if (o_inst_pc !== exp_pc) begin
                    n_fail++; $display("FAIL wrap_pc got %h want %h", o_inst_pc, exp_pc);
                end
                if (o_inst !== ~exp_pc) begin
                    n_fail++; $display("FAIL wrap_data got %h want %h", o_inst, ~exp_pc);
                end
                exp_pc += 32'd4; ninst++;
            end
            tick();
        end
        n_checks++;
        if (ninst != 3) begin
            n_fail++; $display("FAIL wrap_inst_count got %0d want 3", ninst);
        end
    endtask

    task automatic test_error_and_reset;
        mem_en = 1'b0; mem_rdy = 1'b0; dec_rdy = 1'b1; mem_lat = 1;
        do_reset();
        inj_valid = 1'b1; inj_data = 32'hDEAD_BEEF;
        tick();
        inj_valid = 1'b0;
        #1;
        n_checks += 2;
        if (o_rsp_err !== 1'b1) begin
            n_fail++; $display("FAIL err_set got %0b want 1", o_rsp_err);
        end
        if (o_inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL err_fifo_unchanged got %0b want 0", o_inst_valid);
        end
        tick(); tick();
        n_checks += 2;
        if (o_rsp_err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky got %0b want 1", o_rsp_err);
        end
        if (o_inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL err_no_inst got %0b want 0", o_inst_valid);
        end
        reset = 1'b0;
        tick();
        n_checks += 4;
        if (o_rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL err_cleared got %0b want 0", o_rsp_err);
        end
        if (o_imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL err_reset_req got %0b want 0", o_imem_req_valid);
        end
        if (o_inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL err_reset_inst got %0b want 0", o_inst_valid);
        end
        if (o_imem_req_addr !== 32'h0) begin
            n_fail++; $display("FAIL err_reset_addr got %h want 0", o_imem_req_addr);
        end
        reset = 1'b1;
        #1;
        n_checks += 2;
        if (o_imem_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL err_resume_valid got %0b want 1", o_imem_req_valid);
        end
        if (o_imem_req_addr !== 32'h0) begin
            n_fail++; $display("FAIL err_resume_addr got %h want 0", o_imem_req_addr);
        end
        mem_en = 1'b1;
    endtask

    initial begin
        reset = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
        mem_rdy = 1'b1; dec_rdy = 1'b1; mem_en = 1'b1; mem_lat = 1;
        inj_valid = 1'b0; inj_data = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_with_rsp();
        test_wrap();
        test_error_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
